// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Synchronizes and debounces the raw RST_n pushbutton, stretches the
//   reset, then releases NUM_DOM active-low domain resets one after another
//   (bit 0 first). A one-cycle software request also restarts the sequence.
//   The cause of the most recent reset is kept in rst_cause.
//
//   Optional watchdog: compile with RST_SEQ_WDOG_EN defined. Without it,
//   wdog_kick is ignored, wdog_flag is tied low and rst_cause never reads 11.
module rst_sequencer #(
  parameter int NUM_DOM      = 3,     // domain reset outputs, 1..8
  parameter int SYNC_STAGES  = 2,     // RST_n synchronizer depth, >= 2
  parameter int DEBOUNCE_CYC = 16,    // stable samples needed to accept a change
  parameter int STRETCH_CYC  = 8,     // cycles in STRETCH before domain 0 releases
  parameter int GAP_CYC      = 4,     // cycles between domain releases, >= 1
  parameter int WDOG_CYC     = 1024   // watchdog timeout (watchdog build only)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RST_n,
  input  logic               sw_rst_req,
  input  logic               wdog_kick,
  output logic [NUM_DOM-1:0] rst_n_dom,
  output logic               all_rdy,
  output logic [1:0]         rst_cause,
  output logic               wdog_flag
);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_BTN  = 2'b01,
    CAUSE_SW   = 2'b10,
    CAUSE_WDOG = 2'b11
  } cause_e;

  // Debounce counter only needs to reach DEBOUNCE_CYC-1.
  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  // One timer serves both the stretch and the inter-domain gap.
  localparam int TC_MAX = (STRETCH_CYC > GAP_CYC) ? STRETCH_CYC : GAP_CYC;
  localparam int TC_W   = (TC_MAX > 1) ? $clog2(TC_MAX) : 1;
  localparam logic [TC_W-1:0] STRETCH_LAST = TC_W'(STRETCH_CYC - 1);
  localparam logic [TC_W-1:0] GAP_LAST     = TC_W'(GAP_CYC - 1);

  localparam logic [NUM_DOM-1:0] DOM_FIRST = NUM_DOM'(1);

  // Button path
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic [DB_W-1:0]        db_cnt_q;
  logic                   btn_db_q;
  logic                   btn_dly_q;

  // Sequencer
  state_e                 state_q;
  logic [TC_W-1:0]        tcnt_q;
  logic [NUM_DOM-1:0]     rst_n_dom_q;
  logic [NUM_DOM-1:0]     dom_d;
  logic                   all_rdy_q;
  cause_e                 cause_q;
  cause_e                 cause_d;

  // Trigger decode
  logic                   btn_fall;
  logic                   wdog_to;
  logic                   trig;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Synchronize RST_n, then accept a new level only after it has differed
  // from the debounced level for DEBOUNCE_CYC consecutive samples.
  // NOTE: every flop in the design is written with <= so that all registers
  // sample the pre-edge values, which is what makes the shift chain work.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      btn_db_q  <= 1'b0;
      btn_dly_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], RST_n};
      btn_dly_q <= btn_db_q;
      if (btn_sync != btn_db_q) begin
        if (db_cnt_q == DB_LAST) begin
          btn_db_q <= btn_sync;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

`ifdef RST_SEQ_WDOG_EN
  localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            wdog_flag_q;

  // The watchdog only expires in RUN, and only if not kicked this cycle.
  assign wdog_to   = (state_q == ST_RUN) && !wdog_kick && (wd_cnt_q == WD_LAST);
  assign wdog_flag = wdog_flag_q;

  // Watchdog counts RUN cycles since the last kick; the flag stays set until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q    <= '0;
      wdog_flag_q <= 1'b0;
    end else begin
      if ((state_q != ST_RUN) || wdog_kick || trig) begin
        wd_cnt_q <= '0;
      end else begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      if (wdog_to) begin
        wdog_flag_q <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog_kick;

  assign unused_wdog_kick = wdog_kick;
  assign wdog_to          = 1'b0;
  assign wdog_flag        = 1'b0;
`endif

  // Trigger detection, cause priority and the next release pattern.
  // NOTE: each variable gets a value on every path through this block, so no
  // latch is inferred.
  always_comb begin
    btn_fall = btn_dly_q & ~btn_db_q;
    trig     = btn_fall | sw_rst_req | wdog_to;
    if (btn_fall) begin
      cause_d = CAUSE_BTN;
    end else if (wdog_to) begin
      cause_d = CAUSE_WDOG;
    end else begin
      cause_d = CAUSE_SW;
    end
    // Thermometer: the next domain joins the ones already released.
    dom_d = (rst_n_dom_q << 1) | DOM_FIRST;
  end

  // Sequencer FSM with registered outputs. A trigger in any state drops all
  // domains at once and restarts from ASSERT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ASSERT;
      tcnt_q      <= '0;
      rst_n_dom_q <= '0;
      all_rdy_q   <= 1'b0;
      cause_q     <= CAUSE_POR;
    end else if (trig) begin
      state_q     <= ST_ASSERT;
      tcnt_q      <= '0;
      rst_n_dom_q <= '0;
      all_rdy_q   <= 1'b0;
      cause_q     <= cause_d;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rst_n_dom_q <= '0;
          all_rdy_q   <= 1'b0;
          tcnt_q      <= '0;
          if (btn_db_q) begin
            state_q <= ST_STRETCH;
          end
        end
        ST_STRETCH: begin
          if (tcnt_q == STRETCH_LAST) begin
            tcnt_q      <= '0;
            rst_n_dom_q <= dom_d;
            // With a single domain there is no gap phase.
            state_q     <= (&dom_d) ? ST_RUN : ST_RELEASE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (tcnt_q == GAP_LAST) begin
            tcnt_q      <= '0;
            rst_n_dom_q <= dom_d;
            if (&dom_d) begin
              state_q <= ST_RUN;
            end
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          all_rdy_q <= 1'b1;
        end
        default: begin
          state_q <= ST_ASSERT;
        end
      endcase
    end
  end

  assign rst_n_dom = rst_n_dom_q;
  assign all_rdy   = all_rdy_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer
//   Expected outputs are stamped with the clock edge after which they must
//   hold, queued when the stimulus is driven, and compared on the following
//   falling edge. Release timing is taken from a table of offsets relative
//   to the cycle the sequencer leaves ASSERT.
module tb_rst_sequencer;

  localparam int ND = 3;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          RST_n      = 1'b1;
  logic          sw_rst_req = 1'b0;
  logic          wdog_kick  = 1'b0;
  logic [ND-1:0] rst_n_dom;
  logic          all_rdy;
  logic [1:0]    rst_cause;
  logic          wdog_flag;

  rst_sequencer #(
    .NUM_DOM      (ND),
    .SYNC_STAGES  (2),
    .DEBOUNCE_CYC (16),
    .STRETCH_CYC  (8),
    .GAP_CYC      (4),
    .WDOG_CYC     (1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RST_n      (RST_n),
    .sw_rst_req (sw_rst_req),
    .wdog_kick  (wdog_kick),
    .rst_n_dom  (rst_n_dom),
    .all_rdy    (all_rdy),
    .rst_cause  (rst_cause),
    .wdog_flag  (wdog_flag)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    string         name;
    int            at;
    logic [ND-1:0] dom;
    logic          rdy;
    logic [1:0]    cause;
    logic          wflag;
  } exp_t;

  typedef struct {
    int            off;
    logic [ND-1:0] dom;
    logic          rdy;
  } rel_t;

  typedef struct {
    string      name;
    int         low_cyc;
    int         sw_off;
    bit         resets;
    logic [1:0] cause;
  } trig_t;

  exp_t  sb[$];
  rel_t  rel_tbl[8];
  trig_t trig_tbl[3];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input int at,
                       input logic [ND+3:0] got, input logic [ND+3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @edge %0d: got {dom,rdy,cause,wflag}=%b, expected %b",
               name, at, got, exp);
    end
  endtask

  task automatic push(input string name, input int at, input logic [ND-1:0] dom,
                      input logic rdy, input logic [1:0] cause, input logic wflag);
    exp_t e;
    e.name  = name;
    e.at    = at;
    e.dom   = dom;
    e.rdy   = rdy;
    e.cause = cause;
    e.wflag = wflag;
    sb.push_back(e);
  endtask

  // Queue the staggered release, t being the edge at which ASSERT is left.
  task automatic apply_rel(input string tag, input int t, input logic [1:0] cause,
                           input logic wflag, input int max_off);
    foreach (rel_tbl[i]) begin
      if (rel_tbl[i].off <= max_off) begin
        push($sformatf("%s+%0d", tag, rel_tbl[i].off), t + rel_tbl[i].off,
             rel_tbl[i].dom, rel_tbl[i].rdy, cause, wflag);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic until_edge(input int e);
    while (edge_cnt < e) step(1);
  endtask

  // Scoreboard: compare every expectation that falls due at this edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == edge_cnt) begin
        check(sb[i].name, edge_cnt, {rst_n_dom, all_rdy, rst_cause, wdog_flag},
              {sb[i].dom, sb[i].rdy, sb[i].cause, sb[i].wflag});
        sb.delete(i);
      end else if (sb[i].at < edge_cnt) begin
        n_vec++;
        n_miss++;
        $display("FAIL %s missed: due @edge %0d, now %0d", sb[i].name, sb[i].at, edge_cnt);
        sb.delete(i);
      end
    end
  end

  initial begin
    int         e0, f, r, s0, t0, k, x;
    logic [1:0] cur_cause;
    logic       cur_wflag;

    // Release profile: offsets from leaving ASSERT (8-cycle stretch, 4-cycle gap).
    rel_tbl[0] = '{8,  3'b000, 1'b0};
    rel_tbl[1] = '{9,  3'b001, 1'b0};
    rel_tbl[2] = '{12, 3'b001, 1'b0};
    rel_tbl[3] = '{13, 3'b011, 1'b0};
    rel_tbl[4] = '{16, 3'b011, 1'b0};
    rel_tbl[5] = '{17, 3'b111, 1'b0};
    rel_tbl[6] = '{18, 3'b111, 1'b1};
    rel_tbl[7] = '{22, 3'b111, 1'b1};

    // Button scenarios from RUN: RST_n low for low_cyc cycles, optional
    // one-cycle sw_rst_req driven sw_off cycles after the fall.
    trig_tbl[0] = '{"glitch", 10, -1, 1'b0, 2'b00};
    trig_tbl[1] = '{"button", 40, -1, 1'b1, 2'b01};
    trig_tbl[2] = '{"simult", 40, 18, 1'b1, 2'b01};

    cur_cause = 2'b00;
    cur_wflag = 1'b0;

    // Reset state while rst is held.
    push("rst_hold_a", 2, 3'b000, 1'b0, 2'b00, 1'b0);
    push("rst_hold_b", 4, 3'b000, 1'b0, 2'b00, 1'b0);
    step(5);

    // Power-up: e0 is the last edge that samples rst=1.
    e0 = edge_cnt;
    push("por_e1",  e0 + 1,  3'b000, 1'b0, 2'b00, 1'b0);
    push("por_e17", e0 + 17, 3'b000, 1'b0, 2'b00, 1'b0);
    apply_rel("por", e0 + 18, 2'b00, 1'b0, 99);
    rst = 1'b0;
    until_edge(e0 + 18 + 24);

    // Button-driven scenarios.
    for (int j = 0; j < 3; j++) begin
      f = edge_cnt;
      r = f + trig_tbl[j].low_cyc;
      if (trig_tbl[j].resets) begin
        push({trig_tbl[j].name, "_pre"},  f + 18, 3'b111, 1'b1, cur_cause, cur_wflag);
        push({trig_tbl[j].name, "_hit"},  f + 19, 3'b000, 1'b0, trig_tbl[j].cause, cur_wflag);
        push({trig_tbl[j].name, "_one"},  f + 20, 3'b000, 1'b0, trig_tbl[j].cause, cur_wflag);
        push({trig_tbl[j].name, "_hold"}, r - 1,  3'b000, 1'b0, trig_tbl[j].cause, cur_wflag);
        apply_rel(trig_tbl[j].name, r + 18, trig_tbl[j].cause, cur_wflag, 99);
        cur_cause = trig_tbl[j].cause;
      end else begin
        push({trig_tbl[j].name, "_a"}, f + 5,  3'b111, 1'b1, cur_cause, cur_wflag);
        push({trig_tbl[j].name, "_b"}, f + 19, 3'b111, 1'b1, cur_cause, cur_wflag);
        push({trig_tbl[j].name, "_c"}, f + 25, 3'b111, 1'b1, cur_cause, cur_wflag);
      end
      RST_n = 1'b0;
      for (int i = 0; i < trig_tbl[j].low_cyc; i++) begin
        sw_rst_req = (i == trig_tbl[j].sw_off);
        step(1);
      end
      sw_rst_req = 1'b0;
      RST_n      = 1'b1;
      until_edge(trig_tbl[j].resets ? (r + 18 + 24) : (f + 30));
    end

    // Software request from RUN, then again when only domain 0 is out.
    s0 = edge_cnt;
    t0 = s0 + 1;
    push("sw1_pre", s0, 3'b111, 1'b1, cur_cause, cur_wflag);
    push("sw1_hit", t0, 3'b000, 1'b0, 2'b10, cur_wflag);
    apply_rel("sw1", t0, 2'b10, cur_wflag, 9);
    push("sw2_pre", t0 + 10, 3'b001, 1'b0, 2'b10, cur_wflag);
    push("sw2_hit", t0 + 11, 3'b000, 1'b0, 2'b10, cur_wflag);
    apply_rel("sw2", t0 + 11, 2'b10, cur_wflag, 99);
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    until_edge(t0 + 10);
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    cur_cause = 2'b10;
    until_edge(t0 + 11 + 24);

`ifdef RST_SEQ_WDOG_EN
    // Kicks every 1000 cycles keep RUN alive; then silence fires the watchdog.
    k = edge_cnt;
    for (int n = 0; n < 3; n++) begin
      wdog_kick = 1'b1;
      step(1);
      wdog_kick = 1'b0;
      k = edge_cnt;
      push($sformatf("wd_kick%0d", n), k + 999, 3'b111, 1'b1, cur_cause, 1'b0);
      step(999);
    end
    push("wd_quiet", k + 1023, 3'b111, 1'b1, cur_cause, 1'b0);
    push("wd_fire",  k + 1024, 3'b000, 1'b0, 2'b11, 1'b1);
    apply_rel("wd", k + 1024, 2'b11, 1'b1, 99);
    cur_cause = 2'b11;
    cur_wflag = 1'b1;
    until_edge(k + 1024 + 24);
`else
    // Without the watchdog, a long unkicked RUN and stray kicks change nothing.
    k = edge_cnt;
    push("nowd_a", k + 500,  3'b111, 1'b1, cur_cause, 1'b0);
    push("nowd_b", k + 1030, 3'b111, 1'b1, cur_cause, 1'b0);
    push("nowd_c", k + 1100, 3'b111, 1'b1, cur_cause, 1'b0);
    until_edge(k + 600);
    wdog_kick = 1'b1;
    step(1);
    wdog_kick = 1'b0;
    until_edge(k + 1101);
`endif

    // rst in the middle of RUN clears everything, including the flag.
    x = edge_cnt;
    push("rst_mid_a", x + 1, 3'b000, 1'b0, 2'b00, 1'b0);
    push("rst_mid_b", x + 2, 3'b000, 1'b0, 2'b00, 1'b0);
    push("rst_mid_c", x + 3, 3'b000, 1'b0, 2'b00, 1'b0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);

    for (int n = 0; n < 50 && sb.size() > 0; n++) step(1);
    while (sb.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s never compared (due @edge %0d)", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
